// File: rtl/dds_arb_pkg.sv
// Shared types and constants for the DDS reset/config path arbiter.
// State encoding, select codes and the index-to-grant helper live here.
package dds_arb_pkg;

   localparam int NSRC = 3;
   localparam logic [1:0] CHG_HOLD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_GRANT   = 2'd2,
      ST_HOLDOFF = 2'd3
   } arb_state_t;

   function automatic logic [NSRC-1:0] idx_to_onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    idx_to_onehot = 3'b001;
         2'd1:    idx_to_onehot = 3'b010;
         2'd2:    idx_to_onehot = 3'b100;
         default: idx_to_onehot = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/dds_rr_pick3.sv
// Rotating-priority picker for three requesters: the first set request at or
// above ptr wins, wrapping 2 -> 0. Purely combinational.
module dds_rr_pick3
   import dds_arb_pkg::*;
(
   input  logic [NSRC-1:0] req,
   input  logic [1:0]      ptr,
   output logic            valid,
   output logic [1:0]      idx
);

   // NOTE: every output gets a default before the case so no latch can form.
   always_comb begin
      valid = |req;
      idx   = 2'd0;
      case (ptr)
         2'd1: begin
            if      (req[1]) idx = 2'd1;
            else if (req[2]) idx = 2'd2;
            else             idx = 2'd0;
         end
         2'd2: begin
            if      (req[2]) idx = 2'd2;
            else if (req[0]) idx = 2'd0;
            else             idx = 2'd1;
         end
         default: begin
            if      (req[0]) idx = 2'd0;
            else if (req[1]) idx = 2'd1;
            else             idx = 2'd2;
         end
      endcase
   end

endmodule

// File: rtl/dds_sel_arbiter.sv
// Round-robin owner of the shared DDS reset/config path. Guard intervals keep the
// output mux select stable around every grant; the select parks on hold when idle.
module dds_sel_arbiter
   import dds_arb_pkg::*;
#(
   parameter int GUARD_CYC = 4,
   parameter int TMO_W     = 16,
   parameter int TMO_CYC   = 50000
) (
   input  logic            clk_sys,
   input  logic            rst_n,
   input  logic [NSRC-1:0] req,
   input  logic [NSRC-1:0] done,
   output logic [NSRC-1:0] gnt,
   output logic [1:0]      change,
   output logic            busy,
   output logic            tmo_err,
   output logic [1:0]      tmo_src
);

   localparam int GW = $clog2(GUARD_CYC + 1);

   arb_state_t      state;
   logic [1:0]      ptr;
   logic [1:0]      win;
   logic [GW-1:0]   g_cnt;
   logic [TMO_W-1:0] tmo_cnt;

   logic            pick_valid;
   logic [1:0]      pick_idx;
   logic [NSRC-1:0] win_oh;
   logic            req_win;
   logic            done_win;

   dds_rr_pick3 u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Only the current winner's req/done lines are ever looked at.
   assign win_oh   = idx_to_onehot(win);
   assign req_win  = |(req & win_oh);
   assign done_win = |(done & win_oh);

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         gnt     <= '0;
         change  <= CHG_HOLD;
         busy    <= 1'b0;
         tmo_err <= 1'b0;
         tmo_src <= 2'd0;
         ptr     <= 2'd0;
         win     <= 2'd0;
         g_cnt   <= '0;
         tmo_cnt <= '0;
      end else begin
         tmo_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state  <= ST_SETUP;
                  win    <= pick_idx;
                  change <= pick_idx;
                  g_cnt  <= '0;
                  busy   <= 1'b1;
               end else begin
                  change <= CHG_HOLD;
                  busy   <= 1'b0;
               end
            end
            ST_SETUP: begin
               // A requester that withdraws before its grant still gets a full holdoff.
               if (!req_win) begin
                  state <= ST_HOLDOFF;
                  g_cnt <= '0;
               end else if (g_cnt == GW'(GUARD_CYC)) begin
                  state   <= ST_GRANT;
                  gnt     <= win_oh;
                  tmo_cnt <= '0;
               end else begin
                  g_cnt <= g_cnt + 1'b1;
               end
            end
            ST_GRANT: begin
               if (done_win || !req_win) begin
                  state <= ST_HOLDOFF;
                  gnt   <= '0;
                  g_cnt <= '0;
               end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                  state   <= ST_HOLDOFF;
                  gnt     <= '0;
                  g_cnt   <= '0;
                  tmo_err <= 1'b1;
                  tmo_src <= win;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (g_cnt == GW'(GUARD_CYC - 1)) begin
                  state  <= ST_IDLE;
                  change <= CHG_HOLD;
                  busy   <= 1'b0;
                  ptr    <= (win == 2'd2) ? 2'd0 : win + 2'd1;
               end else begin
                  g_cnt <= g_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
